// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the fetch/data memory port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY_IF, BUSY_DM, RESP)
//   grant_e     : grant encoding (GNT_IF = 0, GNT_DM = 1)
//   ABORT_DATA  : read data returned to a requester whose access timed out
//   arb_pick    : chooses the winner among pending requests
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_e;

  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

  // On a conflict the requester that did not win the previous conflict is
  // served; a lone request always wins.
  function automatic grant_e arb_pick(input logic i_if_req,
                                      input logic i_dm_req,
                                      input grant_e i_last);
    grant_e w_win;
    if (i_if_req && i_dm_req) begin
      if (i_last == GNT_IF) w_win = GNT_DM;
      else                  w_win = GNT_IF;
    end else if (i_dm_req) begin
      w_win = GNT_DM;
    end else begin
      w_win = GNT_IF;
    end
    return w_win;
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// -----------------------------------------------------------------------------
// arb_sat_counter
// Free-running event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk          in   clock, rising edge
//   rst_async_n  in   asynchronous active-low reset (count -> 0)
//   i_en         in   count this cycle
//   o_count      out  registered count value
// -----------------------------------------------------------------------------
module arb_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_async_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port unified memory between the fetch (IF) and memory
// (DM) pipeline stages. Requests are serialised through a four-state FSM
// (IDLE -> BUSY_x -> RESP -> IDLE), read data is returned per requester with a
// one-cycle done pulse, and an access that waits MAX_WAIT cycles without
// mem_ready is aborted (sticky timeout_err, ABORT_DATA returned for reads).
//
// Optional build macro: MEM_ARB_PERF_CNT_EN
//   defined     : conflict_cnt / wait_cnt are saturating 32-bit counters
//   not defined : both counter ports are tied to zero, no counter flops
//
// Ports:
//   clk, rst_async_n            clock / asynchronous active-low reset
//   if_req, if_addr             fetch request (held until if_done)
//   if_rdata, if_done           fetched word and one-cycle completion pulse
//   dm_req, dm_we, dm_addr,
//   dm_wdata                    data request (held until dm_done)
//   dm_rdata, dm_done           load data and one-cycle completion pulse
//   mem_valid, mem_we, mem_addr,
//   mem_wdata                   shared memory request (registered)
//   mem_ready, mem_rdata        shared memory response
//   stall_if, stall_mem         combinational stall requests to hazard logic
//   timeout_err                 sticky abort flag
//   conflict_cnt, wait_cnt      performance counters
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_async_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              timeout_err,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       wait_cnt
);

  // Abort fires in the BUSY cycle where the wait count would reach MAX_WAIT.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  // State and datapath registers
  arb_state_e        r_state;
  grant_e            r_last_grant;
  logic              r_mem_valid;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_done;
  logic              r_dm_done;
  logic              r_timeout_err;
  logic [7:0]        r_wait;

  // Next-state values
  arb_state_e        w_state_next;
  grant_e            w_last_grant_next;
  logic              w_mem_valid_next;
  logic              w_mem_we_next;
  logic [ADDR_W-1:0] w_mem_addr_next;
  logic [DATA_W-1:0] w_mem_wdata_next;
  logic [DATA_W-1:0] w_if_rdata_next;
  logic [DATA_W-1:0] w_dm_rdata_next;
  logic              w_if_done_next;
  logic              w_dm_done_next;
  logic              w_timeout_err_next;
  logic [7:0]        w_wait_next;

  grant_e            w_gnt;
  logic              w_busy;
  logic              w_busy_dm;

  assign w_gnt     = arb_pick(if_req, dm_req, r_last_grant);
  assign w_busy    = (r_state == BUSY_IF) || (r_state == BUSY_DM);
  assign w_busy_dm = (r_state == BUSY_DM);

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      r_state       <= IDLE;
      r_last_grant  <= GNT_IF;
      r_mem_valid   <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_if_rdata    <= '0;
      r_dm_rdata    <= '0;
      r_if_done     <= 1'b0;
      r_dm_done     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wait        <= '0;
    end else begin
      r_state       <= w_state_next;
      r_last_grant  <= w_last_grant_next;
      r_mem_valid   <= w_mem_valid_next;
      r_mem_we      <= w_mem_we_next;
      r_mem_addr    <= w_mem_addr_next;
      r_mem_wdata   <= w_mem_wdata_next;
      r_if_rdata    <= w_if_rdata_next;
      r_dm_rdata    <= w_dm_rdata_next;
      r_if_done     <= w_if_done_next;
      r_dm_done     <= w_dm_done_next;
      r_timeout_err <= w_timeout_err_next;
      r_wait        <= w_wait_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_last_grant_next  = r_last_grant;
    w_mem_valid_next   = r_mem_valid;
    w_mem_we_next      = r_mem_we;
    w_mem_addr_next    = r_mem_addr;
    w_mem_wdata_next   = r_mem_wdata;
    w_if_rdata_next    = r_if_rdata;
    w_dm_rdata_next    = r_dm_rdata;
    w_if_done_next     = 1'b0;
    w_dm_done_next     = 1'b0;
    w_timeout_err_next = r_timeout_err;
    w_wait_next        = r_wait;

    case (r_state)
      IDLE: begin
        if (if_req || dm_req) begin
          // Fairness history moves only when two requests actually compete,
          // so a lone access never changes who wins the next conflict.
          if (if_req && dm_req) w_last_grant_next = w_gnt;
          w_mem_valid_next = 1'b1;
          w_wait_next      = '0;
          if (w_gnt == GNT_DM) begin
            w_state_next     = BUSY_DM;
            w_mem_we_next    = dm_we;
            w_mem_addr_next  = dm_addr;
            w_mem_wdata_next = dm_wdata;
          end else begin
            w_state_next     = BUSY_IF;
            w_mem_we_next    = 1'b0;
            w_mem_addr_next  = if_addr;
            w_mem_wdata_next = '0;
          end
        end
      end

      BUSY_IF, BUSY_DM: begin
        if (mem_ready) begin
          w_mem_valid_next = 1'b0;
          w_state_next     = RESP;
          if (w_busy_dm) begin
            // Stores leave the last load value visible on dm_rdata.
            if (!r_mem_we) w_dm_rdata_next = mem_rdata;
            w_dm_done_next = 1'b1;
          end else begin
            w_if_rdata_next = mem_rdata;
            w_if_done_next  = 1'b1;
          end
        end else if (r_wait == WAIT_LAST) begin
          // Memory never answered: release the bus and still complete the
          // requester so the pipeline cannot deadlock.
          w_mem_valid_next   = 1'b0;
          w_state_next       = RESP;
          w_timeout_err_next = 1'b1;
          if (w_busy_dm) begin
            if (!r_mem_we) w_dm_rdata_next = DATA_W'(ABORT_DATA);
            w_dm_done_next = 1'b1;
          end else begin
            w_if_rdata_next = DATA_W'(ABORT_DATA);
            w_if_done_next  = 1'b1;
          end
        end else begin
          w_wait_next = r_wait + 8'd1;
        end
      end

      RESP: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign mem_valid   = r_mem_valid;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign if_rdata    = r_if_rdata;
  assign dm_rdata    = r_dm_rdata;
  assign if_done     = r_if_done;
  assign dm_done     = r_dm_done;
  assign timeout_err = r_timeout_err;

  // Stall follows the raw request so the stage freezes in the request cycle.
  assign stall_if  = if_req & ~r_if_done;
  assign stall_mem = dm_req & ~r_dm_done;

`ifdef MEM_ARB_PERF_CNT_EN
  logic w_conflict_en;
  logic w_wait_en;

  assign w_conflict_en = (r_state == IDLE) & if_req & dm_req;
  assign w_wait_en     = w_busy & ~mem_ready;

  arb_sat_counter #(.WIDTH(32)) u_conflict_cnt (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .i_en        (w_conflict_en),
    .o_count     (conflict_cnt)
  );

  arb_sat_counter #(.WIDTH(32)) u_wait_cnt (
    .clk         (clk),
    .rst_async_n (rst_async_n),
    .i_en        (w_wait_en),
    .o_count     (wait_cnt)
  );
`else
  logic w_unused_busy;
  assign w_unused_busy = w_busy;
  assign conflict_cnt  = '0;
  assign wait_cnt      = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Scoreboard bench for mem_port_arbiter: each request pushes its expected
// memory-side command and response into a queue; a monitor checks the bus
// while mem_valid is high and pops/compares on each done pulse. A simple
// behavioural memory answers with a programmable number of wait cycles.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int MAX_WAIT = 15;
`ifdef MEM_ARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    bit          port;   // 0 = IF, 1 = DM
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;    // cycles from first mem_valid cycle to done cycle
  } txn_t;

  logic        clk;
  logic        rst_async_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        timeout_err;
  logic [31:0] conflict_cnt;
  logic [31:0] wait_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          mem_wait_cfg = 0;
  logic [31:0] mem_arr [logic [31:0]];
  txn_t        sb [$];
  logic [31:0] model_dm_rdata = 32'h0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst_async_n  (rst_async_n),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_done      (if_done),
    .dm_req       (dm_req),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .dm_rdata     (dm_rdata),
    .dm_done      (dm_done),
    .mem_valid    (mem_valid),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .stall_if     (stall_if),
    .stall_mem    (stall_mem),
    .timeout_err  (timeout_err),
    .conflict_cnt (conflict_cnt),
    .wait_cnt     (wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return ~a;
  endfunction

  // Behavioural memory: ready after mem_wait_cfg low cycles, garbage otherwise.
  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (mem_valid) begin
      if (wcnt >= mem_wait_cfg) begin
        mem_ready = 1'b1;
        if (mem_we) begin
          mem_arr[mem_addr] = mem_wdata;
          mem_rdata = $urandom;
        end else begin
          mem_rdata = mem_read(mem_addr);
        end
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      wcnt = 0;
    end
  end

  // Monitor: bus command against queue head, response on done.
  bit prev_valid = 1'b0;
  int grant_cyc  = 0;
  always @(posedge clk) begin
    txn_t t;
    #1;
    if (!rst_async_n) begin
      prev_valid = 1'b0;
    end else begin
      if (mem_valid) begin
        if (!prev_valid) grant_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_grant", 32'(mem_valid), 32'd0);
        end else if (!prev_valid) begin
          check("mem_addr", mem_addr, sb[0].addr);
          check("mem_we", 32'(mem_we), 32'(sb[0].we));
          if (sb[0].we) check("mem_wdata", mem_wdata, sb[0].wdata);
        end else begin
          check("mem_addr_hold", mem_addr, sb[0].addr);
          check("mem_we_hold", 32'(mem_we), 32'(sb[0].we));
          if (sb[0].we) check("mem_wdata_hold", mem_wdata, sb[0].wdata);
        end
      end
      prev_valid = mem_valid;
      if (if_done || dm_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(if_done | dm_done), 32'd0);
        end else begin
          t = sb.pop_front();
          check("done_both", 32'(if_done & dm_done), 32'd0);
          check("done_port", 32'(dm_done), 32'(t.port));
          check("done_latency", 32'(cyc - grant_cyc), 32'(t.lat));
          if (t.port) check("dm_rdata", dm_rdata, t.rdata);
          else        check("if_rdata", if_rdata, t.rdata);
          $display("[TB] txn %s we=%0d addr=%08h rdata=%08h exp=%08h lat=%0d",
                   t.port ? "DM" : "IF", t.we, t.addr,
                   t.port ? dm_rdata : if_rdata, t.rdata, cyc - grant_cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit port, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input int lat);
    txn_t t;
    t.port  = port;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    if (port && we) t.rdata = model_dm_rdata;
    else            t.rdata = rdata;
    if (port && !we) model_dm_rdata = rdata;
    t.lat = lat;
    sb.push_back(t);
  endtask

  task automatic wait_done(input bit port, input int budget, input string tag, output int dcyc);
    bit seen;
    seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (port ? dm_done : if_done) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2;
    bit seen;
    rst_async_n = 1'b0;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    mem_arr[32'h40]  = 32'h1234ABCD;
    mem_arr[32'h44]  = 32'h00000013;
    mem_arr[32'h48]  = 32'h00100093;
    mem_arr[32'h100] = 32'h0BADF00D;
    mem_arr[32'h104] = 32'h55AA33CC;
    mem_arr[32'h80]  = 32'h11110000;
    mem_arr[32'h84]  = 32'h22220000;

    // Reset state
    repeat (3) step();
    check("rst_mem_valid", 32'(mem_valid), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_done", 32'(if_done), 0);
    check("rst_dm_done", 32'(dm_done), 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_conflict_cnt", conflict_cnt, 0);
    check("rst_wait_cnt", wait_cnt, 0);
    rst_async_n = 1'b1;
    step();

    // 1) Single zero-wait fetch, cycle-exact
    step();
    push(0, 0, 32'h40, 0, 32'h1234ABCD, 1);
    if_addr = 32'h40; if_req = 1'b1;
    @(negedge clk);
    check("t1_c0_stall_if", 32'(stall_if), 1);
    check("t1_c0_mem_valid", 32'(mem_valid), 0);
    @(negedge clk);
    check("t1_c1_mem_valid", 32'(mem_valid), 1);
    check("t1_c1_stall_if", 32'(stall_if), 1);
    @(negedge clk);
    check("t1_c2_if_done", 32'(if_done), 1);
    check("t1_c2_if_rdata", if_rdata, 32'h1234ABCD);
    check("t1_c2_stall_if", 32'(stall_if), 0);
    check("t1_c2_stall_mem", 32'(stall_mem), 0);
    if_req = 1'b0;
    @(negedge clk);
    check("t1_c3_if_done", 32'(if_done), 0);
    check("t1_c3_mem_valid", 32'(mem_valid), 0);

    // 2) Conflict from reset history: DM first, then IF; next conflict IF first
    step();
    push(1, 0, 32'h100, 0, 32'h0BADF00D, 1);
    push(0, 0, 32'h44, 0, 32'h00000013, 1);
    dm_addr = 32'h100; dm_we = 0; dm_req = 1; if_addr = 32'h44; if_req = 1;
    @(negedge clk);
    check("t2_stall_mem", 32'(stall_mem), 1);
    wait_done(1, 20, "t2a_dm", d1); dm_req = 0;
    wait_done(0, 20, "t2a_if", d2); if_req = 0;
    step();
    push(0, 0, 32'h48, 0, 32'h00100093, 1);
    push(1, 0, 32'h104, 0, 32'h55AA33CC, 1);
    if_addr = 32'h48; if_req = 1; dm_addr = 32'h104; dm_req = 1;
    wait_done(0, 20, "t2b_if", d1); if_req = 0;
    wait_done(1, 20, "t2b_dm", d2); dm_req = 0;
    step();
    check("t2_conflict_cnt", conflict_cnt, PERF ? 32'd2 : 32'd0);

    // 3) Store with 3 wait cycles
    mem_wait_cfg = 3;
    push(1, 1, 32'h200, 32'hCAFEF00D, 0, 4);
    dm_addr = 32'h200; dm_wdata = 32'hCAFEF00D; dm_we = 1; dm_req = 1;
    wait_done(1, 20, "t3_store", d1); dm_req = 0; dm_we = 0;
    step();
    check("t3_wait_cnt", wait_cnt, PERF ? 32'd3 : 32'd0);
    check("t3_timeout_err", 32'(timeout_err), 0);

    // 4) Memory never ready: abort, then good accesses keep the sticky flag
    mem_wait_cfg = 100000;
    push(1, 0, 32'h300, 0, 32'hDEADBEEF, MAX_WAIT);
    dm_addr = 32'h300; dm_req = 1;
    wait_done(1, 40, "t4_abort", d1); dm_req = 0;
    check("t4_timeout_err", 32'(timeout_err), 1);
    mem_wait_cfg = 0;
    step();
    push(1, 0, 32'h200, 0, 32'hCAFEF00D, 1);
    dm_addr = 32'h200; dm_req = 1;
    wait_done(1, 20, "t4_load", d1); dm_req = 0;
    push(0, 0, 32'h40, 0, 32'h1234ABCD, 1);
    if_addr = 32'h40; if_req = 1;
    wait_done(0, 20, "t4_fetch", d1); if_req = 0;
    step();
    check("t4_timeout_sticky", 32'(timeout_err), 1);
    check("t4_wait_cnt", wait_cnt, PERF ? 32'(3 + MAX_WAIT) : 32'd0);

    // 5) Back-to-back fetches, request held across done
    push(0, 0, 32'h80, 0, 32'h11110000, 1);
    push(0, 0, 32'h84, 0, 32'h22220000, 1);
    if_addr = 32'h80; if_req = 1;
    wait_done(0, 20, "t5_first", d1);
    if_addr = 32'h84;
    wait_done(0, 20, "t5_second", d2); if_req = 0;
    check("t5_gap", 32'(d2 - d1), 32'd3);
    repeat (3) step();
    check("t5_sb_empty", 32'(sb.size()), 0);

    // 6) Reset in the middle of a fetch
    mem_wait_cfg = 100000;
    push(0, 0, 32'h90, 0, 0, 1);
    if_addr = 32'h90; if_req = 1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (mem_valid) seen = 1'b1;
    end
    check("t6_grant_seen", 32'(seen), 1);
    step();
    #2;
    rst_async_n = 1'b0;
    #1;
    check("t6_rst_mem_valid", 32'(mem_valid), 0);
    check("t6_rst_if_done", 32'(if_done), 0);
    check("t6_rst_timeout_err", 32'(timeout_err), 0);
    check("t6_rst_wait_cnt", wait_cnt, 0);
    check("t6_rst_dm_rdata", dm_rdata, 0);
    sb.delete();
    if_req = 0;
    repeat (2) step();
    rst_async_n = 1'b1;
    mem_wait_cfg = 0;
    repeat (4) step();
    check("t6_no_done", 32'(sb.size()), 0);
    push(0, 0, 32'h44, 0, 32'h00000013, 1);
    if_addr = 32'h44; if_req = 1;
    wait_done(0, 20, "t6_refetch", d1); if_req = 0;
    repeat (3) step();
    check("t6_sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares one single-port data/instruction memory between the fetch stage and the memory stage of the 5-stage pipeline processor. It serialises requests, drives the shared memory handshake and returns read data to each requester. It also produces the per-stage stall signals that feed the hazard/stall logic that freezes PC and the IR. It sits between the IF/MEM stage logic and a unified memory with variable wait states.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 15, wait cycles tolerated on mem_ready before abort (1..255)

- clk  in  1  clock, rising edge
- rst_async_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_rdata  out  DATA_W  fetched instruction, valid when if_done
- if_done  out  1  one-cycle completion pulse
- dm_req  in  1  data request, held until dm_done
- dm_we  in  1  1=store, 0=load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid when dm_done
- dm_done  out  1  one-cycle completion pulse
- mem_valid  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory accepts/completes access
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- stall_if  out  1  if_req & ~if_done
- stall_mem  out  1  dm_req & ~dm_done
- timeout_err  out  1  sticky abort flag
- conflict_cnt  out  32  cycles both requests pending in IDLE
- wait_cnt  out  32  BUSY cycles with mem_ready low

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
- IDLE: only if_req -> BUSY_IF; only dm_req -> BUSY_DM; both -> requester not granted last (last_grant register, reset = IF, so data wins first conflict); neither -> stay.
- On grant edge: mem_valid<=1, mem_addr/mem_we/mem_wdata latched from winner (mem_we=0 for IF).
- BUSY_x: hold mem_* stable; on mem_ready=1 capture mem_rdata into x_rdata (loads/fetches only; stores leave dm_rdata unchanged), mem_valid<=0, -> RESP.
- RESP: x_done=1 for exactly this cycle; requests ignored; -> IDLE.
- Timeout: wait counter clears on grant, increments each BUSY cycle with mem_ready=0; when it reaches MAX_WAIT, abort: mem_valid<=0, x_rdata<=32'hDEADBEEF (reads), timeout_err<=1 (sticky until reset), -> RESP (done still pulses).
- mem_ready in IDLE/RESP ignored.
- Requester dropping req mid-BUSY: access still completes; done pulse issued regardless.

## Timing
- Reset (async, low): state IDLE, last_grant IF, all outputs 0 (rdata buses 0, counters 0).
- Zero-wait memory: req high in cycle 0 -> mem_valid cycle 1 -> done and rdata cycle 2 -> IDLE cycle 3. Each extra mem_ready-low cycle adds one.
- Max throughput: one access per 3 cycles; conflicting requester waits an additional full access.
- stall_if/stall_mem are combinational from req and done; all other outputs registered.
- Reset asserted mid-BUSY: mem_valid drops immediately, no done pulse, access lost.

## Configuration
- MEM_ARB_PERF_CNT_EN defined: conflict_cnt and wait_cnt count as above, saturating at 32'hFFFFFFFF.
- Not defined: both ports tied to 0, no counter flops synthesised; arbitration behaviour identical.

## Structure
- Shared package mem_arb_pkg: state enum (IDLE/BUSY_IF/BUSY_DM/RESP), grant encoding (GNT_IF=0, GNT_DM=1), ABORT_DATA constant 32'hDEADBEEF.
- Sub-module arb_sat_counter (32-bit saturating, enable input), instantiated twice inside the MEM_ARB_PERF_CNT_EN guard.

## Test plan
- Single fetch, if_addr=0x40, zero-wait memory returning 0x1234ABCD -> mem_valid cycle 1, if_done and if_rdata=0x1234ABCD cycle 2, stall_if high cycles 0-1.
- Both requests from reset (dm load 0x100, fetch 0x44) -> DM served first, IF next; second simultaneous conflict -> IF first; conflict_cnt=2 with macro, 0 without.
- Store dm_addr=0x200 wdata=0xCAFEF00D, memory 3 wait cycles -> mem_we=1, addr/wdata stable 4 cycles, dm_done cycle 5, wait_cnt=3, dm_rdata unchanged.
- mem_ready never asserted, MAX_WAIT=15 -> abort after 15 wait cycles, dm_rdata=0xDEADBEEF, dm_done pulses, timeout_err stays 1 through later good accesses.
- rst_async_n low mid-BUSY_IF -> mem_valid 0 same cycle, no if_done; after release, new fetch completes normally.
- Back-to-back fetches with req held across done -> second access starts cycle after RESP, no duplicate service of the first address.
